// File: rtl/ccd_trigger_scheduler_if.sv
// Request/trigger bundle between requesters and the shared crossing-trigger scheduler.
// The scheduler takes the slave side; the requester/control side takes master.
interface ccd_trigger_scheduler_if #(
  parameter int N = 4
) ();
  localparam int IDW = $clog2(N);

  logic           en;
  logic [N-1:0]   req;
  logic           clr_ovr;
  logic           trig_o;
  logic [IDW-1:0] trig_id;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovr;
  logic           busy;

  modport master (
    output en, req, clr_ovr,
    input  trig_o, trig_id, pend, ovr, busy
  );

  modport slave (
    input  en, req, clr_ovr,
    output trig_o, trig_id, pend, ovr, busy
  );
endinterface

// File: rtl/ccd_trigger_scheduler.sv
// Round-robin scheduler sharing one toggle-synchronized trigger channel among N requesters,
// with a hold-off countdown between pulses so the destination synchronizer never misses an edge.
//
// state | meaning
// IDLE  | may grant the next pending requester when en is high
// HOLD  | hold-off countdown after a grant; en ignored, trig_o low
module ccd_trigger_scheduler #(
  parameter int N       = 4,
  parameter int HOLDOFF = 8
) (
  input logic                    clk,
  input logic                    rst,
  ccd_trigger_scheduler_if.slave bus
);
  localparam int IDW = $clog2(N);
  localparam int CW  = ($clog2(HOLDOFF) > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [N-1:0]   ovr_q, ovr_d;
  logic           trig_q, trig_d;
  logic [IDW-1:0] id_q, id_d;
  logic           busy_q, busy_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   gnt_vec;
  int             idx;

  // Search starts just after the last winner so it ends up with lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!win_found && pend_q[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    trig_d  = 1'b0;
    id_d    = id_q;
    gnt_vec = '0;
    case (state_q)
      IDLE: begin
        if (bus.en && win_found) begin
          trig_d           = 1'b1;
          id_d             = win_id;
          ptr_d            = win_id;
          cnt_d            = CW'(HOLDOFF - 2);
          gnt_vec[win_id]  = 1'b1;
          state_d          = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A request coinciding with its own grant survives as a fresh pending request.
    pend_d = bus.req | (pend_q & ~gnt_vec);
    ovr_d  = (bus.req & pend_q & ~gnt_vec) | (ovr_q & {N{~bus.clr_ovr}});
    // busy lags the state by one cycle so it covers exactly the cycles after the pulse.
    busy_d = (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDW'(N - 1);
      pend_q  <= '0;
      ovr_q   <= '0;
      trig_q  <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      trig_q  <= trig_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.trig_o  = trig_q;
  assign bus.trig_id = id_q;
  assign bus.pend    = pend_q;
  assign bus.ovr     = ovr_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ccd_trigger_scheduler.sv
// Bench for ccd_trigger_scheduler: vector table of single-pulse request patterns plus
// hand-built sequences for wrap, overrun, same-cycle re-request, enable and mid-hold reset.
module tb_ccd_trigger_scheduler;
  localparam int N = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ccd_trigger_scheduler_if #(.N(N)) bus ();

  ccd_trigger_scheduler #(.N(N), .HOLDOFF(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    int         ngr;
    logic [7:0] ids;
    logic [3:0] pend1;
  } vec_t;

  vec_t vecs[6];
  int   exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_trig = -1000;
  int   gap = 0;
  int   n_trig = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.trig_o) begin
      n_trig++;
      if (last_trig > -1000) chk("trig_spacing_ge_holdoff", int'((cyc - last_trig) >= H), 1);
      gap       = cyc - last_trig;
      last_trig = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("trig_id", int'(bus.trig_id), e);
      end else begin
        chk("unexpected_trig", 1, 0);
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.req     = '0;
    bus.clr_ovr = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    last_trig = -1000;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() > 0; i++) step();
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n;
    int n0;
    vec_t v;

    vecs[0] = '{4'b0001, 1, 8'h00, 4'b0000};
    vecs[1] = '{4'b1111, 4, 8'hE4, 4'b1110};
    vecs[2] = '{4'b1010, 2, 8'h0D, 4'b1000};
    vecs[3] = '{4'b0100, 1, 8'h02, 4'b0000};
    vecs[4] = '{4'b1001, 2, 8'h0C, 4'b1000};
    vecs[5] = '{4'b0110, 2, 8'h09, 4'b0100};

    bus.en      = 1'b1;
    bus.req     = '0;
    bus.clr_ovr = 1'b0;
    do_reset();
    chk("reset_outputs", int'({bus.trig_o, bus.trig_id, bus.pend, bus.ovr, bus.busy}), 0);

    for (int vi = 0; vi < 6; vi++) begin
      v = vecs[vi];
      do_reset();
      bus.req = v.req;
      for (int g = 0; g < v.ngr; g++) exp_q.push_back(int'((v.ids >> (2 * g)) & 8'h3));
      step();
      chk("pend_latch", int'(bus.pend), int'(v.req));
      chk("no_early_trig", int'(bus.trig_o), 0);
      bus.req = '0;
      step();
      chk("latency_trig", int'(bus.trig_o), 1);
      chk("pend_after_first", int'(bus.pend), int'(v.pend1));
      for (int g = 0; g < v.ngr; g++) begin
        busy_n = 0;
        for (int k = 1; k < H; k++) begin
          step();
          busy_n += int'(bus.busy);
        end
        chk("busy_cycles", busy_n, H - 1);
        step();
        if (g < v.ngr - 1) chk("next_trig_at_holdoff", int'(bus.trig_o), 1);
        else chk("idle_after_last", int'({bus.trig_o, bus.busy}), 0);
      end
      chk("final_pend", int'(bus.pend), 0);
      chk("final_ovr", int'(bus.ovr), 0);
      chk("scoreboard_empty", exp_q.size(), 0);
    end

    // Wrap: last grant was id 1, then 0 and 1 both pending.
    do_reset();
    bus.req = 4'b0010;
    exp_q.push_back(1);
    step();
    bus.req = '0;
    drain(20);
    repeat (H) step();
    bus.req = 4'b0011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    step();
    bus.req = '0;
    drain(40);
    chk("wrap_gap", gap, H);

    // Overrun during hold, then clr_ovr colliding with a new overrun.
    do_reset();
    bus.req = 4'b0011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    step();
    bus.req = '0;
    step();
    bus.req = 4'b0100;
    step();
    bus.req = '0;
    step();
    chk("ovr_before_second_req", int'(bus.ovr), 0);
    bus.req = 4'b0100;
    step();
    chk("ovr_set", int'(bus.ovr), 4'b0100);
    bus.clr_ovr = 1'b1;
    step();
    chk("ovr_set_beats_clear", int'(bus.ovr), 4'b0100);
    bus.req     = '0;
    bus.clr_ovr = 1'b0;
    drain(60);
    repeat (H + 2) step();
    chk("ovr_sticky", int'(bus.ovr), 4'b0100);
    chk("ovr_case_pend_empty", int'(bus.pend), 0);
    bus.clr_ovr = 1'b1;
    step();
    bus.clr_ovr = 1'b0;
    chk("ovr_cleared", int'(bus.ovr), 0);

    // Re-request of id 3 in its own grant cycle.
    do_reset();
    bus.req = 4'b1000;
    exp_q.push_back(3);
    exp_q.push_back(3);
    step();
    step();
    chk("regrant_trig", int'(bus.trig_o), 1);
    chk("regrant_pend_kept", int'(bus.pend), 4'b1000);
    chk("regrant_no_ovr", int'(bus.ovr), 0);
    bus.req = '0;
    drain(30);
    chk("regrant_gap", gap, H);
    step();
    chk("regrant_pend_done", int'(bus.pend), 0);

    // Enable gating, then reset mid-hold.
    do_reset();
    bus.en  = 1'b0;
    bus.req = 4'b0101;
    step();
    bus.req = '0;
    n0 = n_trig;
    repeat (12) step();
    chk("en_low_no_trig", n_trig - n0, 0);
    chk("en_low_pend", int'(bus.pend), 4'b0101);
    exp_q.push_back(0);
    bus.en = 1'b1;
    step();
    chk("en_rise_trig", int'(bus.trig_o), 1);
    chk("en_rise_pend", int'(bus.pend), 4'b0100);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midhold_reset_outputs", int'({bus.trig_o, bus.trig_id, bus.pend, bus.ovr, bus.busy}), 0);
    rst = 1'b0;
    exp_q.delete();
    last_trig = -1000;
    n0 = n_trig;
    repeat (3 * H) step();
    chk("post_reset_no_trig", n_trig - n0, 0);
    chk("post_reset_pend", int'(bus.pend), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
